// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, digit index type and hex-to-segment table for the display scanner
package seg_pkg;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] SEL_NONE = 4'b1111;
   typedef logic [1:0] digit_t;
   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h3F;
         4'h1: return 7'h06;
         4'h2: return 7'h5B;
         4'h3: return 7'h4F;
         4'h4: return 7'h66;
         4'h5: return 7'h6D;
         4'h6: return 7'h7D;
         4'h7: return 7'h07;
         4'h8: return 7'h7F;
         4'h9: return 7'h6F;
         4'hA: return 7'h77;
         4'hB: return 7'h7C;
         4'hC: return 7'h39;
         4'hD: return 7'h5E;
         4'hE: return 7'h79;
         default: return 7'h71;
      endcase
   endfunction
endpackage

// File: rtl/seg_scan_ctrl_hex.sv
// hex_to_seg: hex nibble to active-high {g,f,e,d,c,b,a} segment pattern
//   nibble in 4  hex value
//   seg    out 7 segment pattern, 1 = lit
import seg_pkg::*;
module hex_to_seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   assign seg = hex_seg(nibble);
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scanner with blanking and frame-atomic updates
//   clk, rst            clock, synchronous active-high reset
//   slt[0] / slt[1]     leading-zero suppression / force blank
//   data_in, dp_in      digit nibbles and decimal points offered with load_valid
//   load_ready          pending slot free
//   led_sel, led        active-low digit enables and segments {dp,g..a}
//   frame_tick          one-cycle pulse after each frame end
import seg_pkg::*;
module seg_scan_ctrl #(
   parameter int CLK_DIV = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  slt,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic        load_valid,
   output logic        load_ready,
   output logic [3:0]  led_sel,
   output logic [7:0]  led,
   output logic        frame_tick
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
   logic [CW-1:0] cnt;
   digit_t digit;
   logic [15:0] act_data, pend_data;
   logic [3:0] act_dp, pend_dp;
   logic pend_valid, slot_end, frame_end, show;
   logic [3:0] nib, lz, sel_nx;
   logic [6:0] seg;
   logic [7:0] led_nx;
   assign load_ready = !pend_valid;
   hex_to_seg u_hex (.nibble(nib), .seg(seg));
   always_comb begin
      slot_end = cnt == LAST;
      frame_end = slot_end && digit == 2'd3;
      nib = act_data[{digit, 2'b00} +: 4];
      // lz[k]: digit k and every digit to its left are zero; digit 0 always shows
      lz[3] = act_data[15:12] == 4'h0;
      lz[2] = lz[3] && act_data[11:8] == 4'h0;
      lz[1] = lz[2] && act_data[7:4] == 4'h0;
      lz[0] = 1'b0;
      show = cnt >= BLANK_END && !slt[1] && !(slt[0] && lz[digit]);
      sel_nx = show ? ~(4'b0001 << digit) : SEL_NONE;
      led_nx = show ? ~{act_dp[digit], seg} : SEG_BLANK;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         digit <= '0;
         act_data <= '0;
         act_dp <= '0;
         pend_data <= '0;
         pend_dp <= '0;
         pend_valid <= 1'b0;
         led_sel <= SEL_NONE;
         led <= SEG_BLANK;
         frame_tick <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         digit <= slot_end ? digit + 1'b1 : digit;
         led_sel <= sel_nx;
         led <= led_nx;
         frame_tick <= frame_end;
         // a value accepted on the frame-end cycle lands in pending and waits a whole frame
         if (frame_end && pend_valid) begin
            act_data <= pend_data;
            act_dp <= pend_dp;
            pend_valid <= 1'b0;
         end else if (load_valid && !pend_valid) begin
            pend_data <= data_in;
            pend_dp <= dp_in;
            pend_valid <= 1'b1;
         end
      end
   end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Scan controller and scheduler for the 4-digit multiplexed 7-segment display driven by `top` (`led_sel[3:0]`, `led[7:0]`).
- Time-multiplexes four hex digits with a programmable slot length and an anti-ghosting blank interval.
- Accepts new display values through a valid/ready handshake.
- Commits new values only at frame boundaries, so no frame ever shows a mix of old and new digits.

Parameters:
- CLK_DIV, 100000: clock cycles per digit slot; must be >= BLANK_CYC+1 and >= 2.
- BLANK_CYC, 1000: cycles at the start of each slot with all digits off (anti-ghosting).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- slt  in  2  mode: slt[0]=1 leading-zero suppression; slt[1]=1 display force-blank
- data_in  in  16  four hex nibbles; [15:12] is digit 3 (leftmost), [3:0] is digit 0
- dp_in  in  4  decimal point per digit, 1 = lit
- load_valid  in  1  data_in/dp_in offered
- load_ready  out  1  pending slot free
- led_sel  out  4  digit enables, active-low, at most one bit low
- led  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset: all state is cleared on the clk edge where rst=1, and rst overrides all other inputs. Reset values are:
  - cnt=0, digit=0
  - active={16'h0,4'h0}, pending_valid=0
  - load_ready=1, led_sel=4'b1111, led=8'hFF, frame_tick=0
- Reset asserted mid-slot or mid-handshake discards the pending value.
- Slot counter: cnt runs 0..CLK_DIV-1 and wraps to 0. On the cycle where cnt==CLK_DIV-1:
  - digit increments modulo 4 (3 -> 0).
  - If digit==3 at that point, the frame ends.
- Two-phase per slot, decoded from cnt:
  - BLANK phase (cnt < BLANK_CYC): led_sel=1111, led=FF.
  - SHOW phase (otherwise): led_sel drives bit [digit] low; led = ~{active_dp[digit], hex_seg(active_nibble[digit])}.
- Output latency: led_sel, led and frame_tick are registered. The values at cycle t+1 reflect cnt/digit/active at cycle t.
- Leading-zero suppression (slt[0]=1):
  - Digits 3..1 whose nibble is 0 and whose more-significant digits are all suppressed show blank (led_sel bit stays 1).
  - The dp of a suppressed digit is also off.
  - Digit 0 is never suppressed.
- Force-blank (slt[1]=1): led_sel=1111 and led=FF. Counting, handshake and frame commit continue normally.
- slt is sampled every cycle with no synchronisation. A change takes effect on the next registered output.
- Handshake:
  - load_ready = !pending_valid.
  - Transfer occurs when load_valid && load_ready; data_in/dp_in are captured into pending and pending_valid goes to 1.
- Frame commit: on the frame-end cycle (digit==3, cnt==CLK_DIV-1):
  - If pending_valid, then active<=pending and pending_valid<=0.
  - frame_tick pulses in the next cycle.
- Simultaneous transfer and frame end with pending empty: the new value goes into pending only. It commits at the following frame end, never in the same cycle.
- Pending full at frame end: the commit frees the slot and load_ready=1 from the next cycle.
- load_valid while load_ready=0: no effect. The source holds its data until ready.
- Widths: cnt is $clog2(CLK_DIV) bits and digit is 2 bits. No arithmetic beyond the increment.

Decomposition:
- Shared package seg_pkg:
  - SEG_BLANK=8'hFF and SEL_NONE=4'b1111.
  - Function or constant table for hex 0-F to active-high {g..a} segment patterns.
  - Typedef for the 2-bit digit index.
- Sub-module hex_to_seg (combinational, 4-bit in, 7-bit out). It is instantiated once on the mux-selected nibble.

Test Plan:
- All scenarios use CLK_DIV=8 and BLANK_CYC=2.
- Reset: hold rst 3 cycles, release -> led_sel=1111, led=FF, load_ready=1. The first low led_sel is 1110 in cycle 3 after release, and led shows 8'hC0 (digit '0').
- Scan order and timing: load 16'h1234, dp=0000, wait for commit -> per 8-cycle slot led_sel is 1111 for 2 cycles, then low on one bit for 6 cycles. Order is 1110, 1101, 1011, 0111, repeating. Digit 0 shows '4' (led=8'h99) and digit 3 shows '1' (led=8'hF9). frame_tick pulses every 32 cycles.
- Frame-atomic update: offer 16'hABCD mid-frame -> load_ready drops next cycle. Displayed digits are unchanged until frame_tick, then the next frame shows D,C,B,A on digits 0-3. No mixed frame is observed.
- Back-pressure: second load_valid while pending is full -> ignored, pending keeps its first value. load_ready rises the cycle after frame end, and the second value is accepted then.
- Leading-zero suppression: slt=01, data 16'h0050 -> digits 3 and 2 show led_sel=1111 in their slots, digit 1 shows '5', digit 0 shows '0'. With data 16'h0000 only digit 0 lights.
- Force-blank and mid-run reset: slt=10 -> led_sel=1111 throughout while frame_tick continues. Assert rst mid-slot with pending full -> next cycle pending is cleared, load_ready=1, digit=0, and the display returns to 0000.
